// File: rtl/user_pulser_seq.sv
// Descriptor sequencer for the user-domain pulse-train generator: replays a table
// of pulse-train descriptors, with an idle gap between runs and a programmable pass count.
module user_pulser_seq #(
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          desc_we_i,
    input  logic [IW-1:0] desc_addr_i,
    input  logic [87:0]   desc_wdata_i,
    input  logic          seq_start_i,
    input  logic          seq_abort_i,
    input  logic [IW:0]   seq_len_i,
    input  logic [7:0]    seq_loops_i,
    input  logic [15:0]   seq_gap_i,
    output logic          pls_start_o,
    output logic          pls_stop_o,
    output logic [7:0]    pls_f1_cnt_o,
    output logic [7:0]    pls_f2_cnt_o,
    output logic [7:0]    pls_stop_cnt_o,
    output logic [15:0]   pls_f1_end_o,
    output logic [15:0]   pls_f1_switch_o,
    output logic [15:0]   pls_f2_end_o,
    output logic [15:0]   pls_f2_switch_o,
    input  logic [2:0]    pls_state_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o,
    output logic [IW-1:0] cur_idx_o,
    output logic [7:0]    cur_pass_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] GEN_DONE = 3'd4;

    logic [87:0]   table_q [DEPTH];

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    pass_q, pass_d;
    logic [IW:0]   len_q, len_d;
    logic [7:0]    loops_q, loops_d;
    logic [15:0]   gap_q, gap_d;
    logic [15:0]   gap_cnt_q, gap_cnt_d;
    logic [87:0]   desc_q, desc_d;
    logic [IW-1:0] cur_idx_q, cur_idx_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;

    logic [IW:0]   idx_inc;
    logic [7:0]    pass_inc;
    logic          more_in_pass;

    assign idx_inc      = {1'b0, idx_q} + (IW+1)'(1);
    assign pass_inc     = pass_q + 8'd1;
    assign more_in_pass = idx_inc < len_q;

    // NOTE: the descriptor table is plain storage with no reset, so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (desc_we_i) begin
            table_q[desc_addr_i] <= desc_wdata_i;
        end
    end

    // NOTE: every signal gets a default first, so this block cannot infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        len_d     = len_q;
        loops_d   = loops_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        desc_d    = desc_q;
        cur_idx_d = cur_idx_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seq_start_i) begin
                    len_d   = seq_len_i;
                    loops_d = seq_loops_i;
                    gap_d   = seq_gap_i;
                    if (seq_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = '0;
                        pass_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                desc_d    = table_q[idx_q];
                cur_idx_d = idx_q;
                start_d   = 1'b1;
                state_d   = S_START;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (pls_state_i == GEN_DONE) begin
                    if (more_in_pass) begin
                        idx_d = idx_inc[IW-1:0];
                    end else begin
                        idx_d  = '0;
                        pass_d = pass_inc;
                    end
                    if (!more_in_pass && loops_q != 8'd0 && pass_inc == loops_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q != 16'd0) begin
                        gap_cnt_d = gap_q - 16'd1;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including any pass/config update this cycle.
        if (seq_abort_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            idx_d     = idx_q;
            pass_d    = pass_q;
            desc_d    = desc_q;
            cur_idx_d = cur_idx_q;
            start_d   = 1'b0;
            done_d    = 1'b0;
            stop_d    = 1'b1;
            aborted_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so they all update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            len_q     <= '0;
            loops_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            desc_q    <= '0;
            cur_idx_q <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            len_q     <= len_d;
            loops_q   <= loops_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            desc_q    <= desc_d;
            cur_idx_q <= cur_idx_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign pls_start_o     = start_q;
    assign pls_stop_o      = stop_q;
    assign pls_f1_cnt_o    = desc_q[7:0];
    assign pls_f2_cnt_o    = desc_q[15:8];
    assign pls_stop_cnt_o  = desc_q[23:16];
    assign pls_f1_end_o    = desc_q[39:24];
    assign pls_f1_switch_o = desc_q[55:40];
    assign pls_f2_end_o    = desc_q[71:56];
    assign pls_f2_switch_o = desc_q[87:72];
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign aborted_o       = aborted_q;
    assign cur_idx_o       = cur_idx_q;
    assign cur_pass_o      = pass_q;

endmodule

// File: tb/tb_user_pulser_seq.sv
// Scoreboard bench for user_pulser_seq: directed scenarios push expected events,
// a negedge monitor pops and compares them against a simple generator model.
module tb_user_pulser_seq;

    localparam int DEPTH = 8;
    localparam int IW    = 3;

    typedef enum int {EV_START, EV_DONE, EV_ABORT} ev_e;
    typedef enum int {R_SEQ, R_GEN, R_ABT} ref_e;
    typedef struct {
        ev_e         kind;
        ref_e        rk;
        int          delay;
        int          idx;
        logic [87:0] cfg;
        int          pass;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          desc_we_i = 1'b0;
    logic [IW-1:0] desc_addr_i = '0;
    logic [87:0]   desc_wdata_i = '0;
    logic          seq_start_i = 1'b0;
    logic          seq_abort_i = 1'b0;
    logic [IW:0]   seq_len_i = '0;
    logic [7:0]    seq_loops_i = '0;
    logic [15:0]   seq_gap_i = '0;
    logic          pls_start_o, pls_stop_o;
    logic [7:0]    pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o;
    logic [15:0]   pls_f1_end_o, pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o;
    logic [2:0]    pls_state_i;
    logic          busy_o, done_o, aborted_o;
    logic [IW-1:0] cur_idx_o;
    logic [7:0]    cur_pass_o;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int abort_cyc = 0;
    int gen_done_cyc = 0;
    int start_seen = 0;
    logic [2:0] gen_state;
    int gen_cnt;
    int run_len;
    logic [87:0] dut_cfg;

    user_pulser_seq #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .desc_we_i(desc_we_i), .desc_addr_i(desc_addr_i), .desc_wdata_i(desc_wdata_i),
        .seq_start_i(seq_start_i), .seq_abort_i(seq_abort_i),
        .seq_len_i(seq_len_i), .seq_loops_i(seq_loops_i), .seq_gap_i(seq_gap_i),
        .pls_start_o(pls_start_o), .pls_stop_o(pls_stop_o),
        .pls_f1_cnt_o(pls_f1_cnt_o), .pls_f2_cnt_o(pls_f2_cnt_o), .pls_stop_cnt_o(pls_stop_cnt_o),
        .pls_f1_end_o(pls_f1_end_o), .pls_f1_switch_o(pls_f1_switch_o),
        .pls_f2_end_o(pls_f2_end_o), .pls_f2_switch_o(pls_f2_switch_o),
        .pls_state_i(pls_state_i),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .cur_idx_o(cur_idx_o), .cur_pass_o(cur_pass_o)
    );

    assign dut_cfg = {pls_f2_switch_o, pls_f2_end_o, pls_f1_switch_o, pls_f1_end_o,
                      pls_stop_cnt_o, pls_f2_cnt_o, pls_f1_cnt_o};
    assign pls_state_i = gen_state;
    always_comb run_len = int'(pls_f1_cnt_o) + int'(pls_f2_cnt_o) + int'(pls_stop_cnt_o);

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Generator stand-in: runs for the sum of its counts, then sits in DONE.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gen_state <= 3'd0;
            gen_cnt   <= 0;
        end else if (pls_stop_o) begin
            gen_state <= 3'd0;
        end else if (pls_start_o) begin
            if (run_len == 0) begin
                gen_state    <= 3'd4;
                gen_done_cyc <= cyc + 1;
            end else begin
                gen_state <= 3'd1;
                gen_cnt   <= run_len - 1;
            end
        end else if (gen_state == 3'd1) begin
            if (gen_cnt == 0) begin
                gen_state    <= 3'd4;
                gen_done_cyc <= cyc + 1;
            end else begin
                gen_cnt <= gen_cnt - 1;
            end
        end
    end

    function automatic logic [87:0] mk(input int f1c, input int f2c, input int stc,
                                       input int f1e, input int f1s, input int f2e, input int f2s);
        return {16'(f2s), 16'(f2e), 16'(f1s), 16'(f1e), 8'(stc), 8'(f2c), 8'(f1c)};
    endfunction

    function automatic void push(input ev_e k, input ref_e r, input int d, input int i,
                                 input logic [87:0] c, input int p);
        exp_t e;
        e.kind = k; e.rk = r; e.delay = d; e.idx = i; e.cfg = c; e.pass = p;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input ev_e kind);
        exp_t e;
        int base;
        string nm;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        nm = e.kind.name();
        check({nm, "_kind"}, kind, e.kind);
        case (e.rk)
            R_SEQ:   base = start_cyc;
            R_GEN:   base = gen_done_cyc;
            default: base = abort_cyc;
        endcase
        check({nm, "_delay"}, 96'(cyc - base), 96'(e.delay));
        if (e.pass >= 0) check({nm, "_pass"}, cur_pass_o, 96'(e.pass));
        case (e.kind)
            EV_START: begin
                check("START_idx", cur_idx_o, 96'(e.idx));
                check("START_cfg", dut_cfg, e.cfg);
                check("START_busy", busy_o, 1);
            end
            EV_DONE: begin
                check("DONE_busy", busy_o, 0);
                check("DONE_stop", pls_stop_o, 0);
            end
            default: begin
                check("ABORT_stop", pls_stop_o, 1);
                check("ABORT_busy", busy_o, 0);
                check("ABORT_no_done", done_o, 0);
            end
        endcase
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (pls_start_o || pls_stop_o) check("start_stop_exclusive", 96'(pls_start_o && pls_stop_o), 0);
            if (pls_start_o) begin
                score(EV_START);
                start_seen++;
            end
            if (done_o) score(EV_DONE);
            if (aborted_o) score(EV_ABORT);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_desc(input int addr, input logic [87:0] d);
        desc_we_i = 1'b1; desc_addr_i = IW'(addr); desc_wdata_i = d;
        tick();
        desc_we_i = 1'b0;
    endtask

    task automatic go(input int len, input int loops, input int gap);
        seq_len_i = (IW+1)'(len); seq_loops_i = 8'(loops); seq_gap_i = 16'(gap);
        seq_start_i = 1'b1; start_cyc = cyc;
        tick();
        seq_start_i = 1'b0;
    endtask

    task automatic abort_pulse();
        seq_abort_i = 1'b1; abort_cyc = cyc;
        tick();
        seq_abort_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 96'(n >= budget), 0);
        repeat (4) tick();
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int n = 0;
        while (start_seen < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_start_timeout"}, 96'(n >= budget), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cfg"}, dut_cfg, 0);
        check({name, "_ctrl"}, {pls_start_o, pls_stop_o, busy_o, done_o, aborted_o}, 0);
        check({name, "_idx_pass"}, {cur_idx_o, cur_pass_o}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [87:0] d_single, d0, d1, d2, d_zero, d_long, d_short, d_mid, d_new;
        int base;
        d_single = mk(2, 0, 0, 4, 2, 0, 0);
        d0       = mk(1, 0, 0, 3, 1, 0, 0);
        d1       = mk(2, 1, 0, 5, 2, 6, 3);
        d2       = mk(0, 0, 3, 0, 0, 0, 0);
        d_zero   = mk(0, 0, 0, 7, 7, 7, 7);
        d_long   = mk(50, 0, 0, 99, 40, 0, 0);
        d_short  = mk(1, 0, 0, 2, 1, 0, 0);
        d_mid    = mk(20, 0, 0, 30, 10, 0, 0);
        d_new    = mk(1, 1, 0, 9, 8, 7, 6);

        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        // Single run.
        write_desc(0, d_single);
        push(EV_START, R_SEQ, 2, 0, d_single, 0);
        push(EV_DONE, R_GEN, 1, 0, '0, 1);
        go(1, 1, 0);
        wait_drain("single", 100);

        // Three descriptors, two passes, gap of five.
        write_desc(0, d0);
        write_desc(1, d1);
        write_desc(2, d2);
        for (int i = 0; i < 6; i++)
            push(EV_START, (i == 0) ? R_SEQ : R_GEN, (i == 0) ? 2 : 7, i % 3,
                 (i % 3 == 0) ? d0 : (i % 3 == 1) ? d1 : d2, i / 3);
        push(EV_DONE, R_GEN, 1, 0, '0, 2);
        go(3, 2, 5);
        wait_drain("three", 300);

        // Empty list.
        push(EV_DONE, R_SEQ, 1, 0, '0, -1);
        go(0, 1, 0);
        wait_drain("len0", 20);

        // All-zero-count entry.
        write_desc(0, d_short);
        write_desc(1, d_zero);
        push(EV_START, R_SEQ, 2, 0, d_short, 0);
        push(EV_START, R_GEN, 2, 1, d_zero, 0);
        push(EV_DONE, R_GEN, 1, 0, '0, 1);
        go(2, 1, 0);
        wait_drain("zero", 100);

        // Abort while waiting on the generator, then a clean rerun.
        write_desc(0, d_long);
        base = start_seen;
        push(EV_START, R_SEQ, 2, 0, d_long, 0);
        go(1, 1, 0);
        wait_starts("abort_wait", base + 1, 50);
        repeat (5) tick();
        push(EV_ABORT, R_ABT, 1, 0, '0, 0);
        abort_pulse();
        wait_drain("abort_wait", 50);
        write_desc(0, d_short);
        push(EV_START, R_SEQ, 2, 0, d_short, 0);
        push(EV_DONE, R_GEN, 1, 0, '0, 1);
        go(1, 1, 0);
        wait_drain("rerun", 100);

        // Abort during the idle gap.
        write_desc(1, d0);
        base = start_seen;
        push(EV_START, R_SEQ, 2, 0, d_short, 0);
        go(2, 1, 20);
        wait_starts("abort_gap", base + 1, 50);
        for (int n = 0; n < 50 && gen_state != 3'd4; n++) tick();
        repeat (3) tick();
        check("busy_in_gap", busy_o, 1);
        push(EV_ABORT, R_ABT, 1, 0, '0, 0);
        abort_pulse();
        wait_drain("abort_gap", 50);

        // Endless looping until abort.
        base = start_seen;
        for (int i = 0; i < 24; i++)
            push(EV_START, (i == 0) ? R_SEQ : R_GEN, 2, i % 2, (i % 2 == 0) ? d_short : d0, i / 2);
        go(2, 0, 0);
        wait_starts("infinite", base + 24, 400);
        push(EV_ABORT, R_ABT, 1, 0, '0, 11);
        abort_pulse();
        wait_drain("infinite", 50);

        // Rewrite the running entry; ignored re-start while busy.
        write_desc(0, d_mid);
        write_desc(1, d_short);
        base = start_seen;
        push(EV_START, R_SEQ, 2, 0, d_mid, 0);
        push(EV_START, R_GEN, 2, 1, d_short, 0);
        push(EV_START, R_GEN, 2, 0, d_new, 1);
        push(EV_START, R_GEN, 2, 1, d_short, 1);
        push(EV_DONE, R_GEN, 1, 0, '0, 2);
        go(2, 2, 0);
        wait_starts("midwrite", base + 1, 50);
        write_desc(0, d_new);
        check("cfg_hold_after_write", dut_cfg, d_mid);
        seq_len_i = 4'd1; seq_start_i = 1'b1;
        tick();
        seq_start_i = 1'b0;
        check("idx_hold_after_write", cur_idx_o, 0);
        wait_drain("midwrite", 200);

        // Asynchronous reset in the middle of a run, then a normal run.
        write_desc(0, d_short);
        write_desc(1, d0);
        base = start_seen;
        for (int i = 0; i < 4; i++)
            push(EV_START, (i == 0) ? R_SEQ : R_GEN, 2, i % 2, (i % 2 == 0) ? d_short : d0, i / 2);
        go(2, 0, 0);
        wait_starts("midreset", base + 4, 100);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        check("queue_empty_before_reset", 96'(exp_q.size()), 0);
        exp_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        push(EV_START, R_SEQ, 2, 0, d_short, 0);
        push(EV_DONE, R_GEN, 1, 0, '0, 1);
        go(1, 1, 0);
        wait_drain("after_reset", 100);

        check("final_queue_empty", 96'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/user_pulser_seq.md
Name: user_pulser_seq

Overview:
Sequencer that drives the user-domain pulse-train generator through a programmable list of pulse-train descriptors. It holds a small descriptor table written from the register interface. On command it loads each descriptor into the generator's configuration inputs, issues a one-cycle start, and waits for the generator's DONE state. It inserts a programmable idle gap between runs and repeats the whole list a programmable number of times. It sits between the user-domain register block and the generator, and is the only driver of the generator's start, stop and configuration inputs.

Parameters:
DEPTH, 8, number of descriptor entries; power of two, at least 2
IW, $clog2(DEPTH), descriptor index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
desc_we_i  in  1  descriptor table write strobe
desc_addr_i  in  IW  descriptor write index
desc_wdata_i  in  88  descriptor {f2_switch[87:72], f2_end[71:56], f1_switch[55:40], f1_end[39:24], stop_cnt[23:16], f2_cnt[15:8], f1_cnt[7:0]}
seq_start_i  in  1  start sequence (single-cycle pulse)
seq_abort_i  in  1  abort sequence (single-cycle pulse)
seq_len_i  in  IW+1  number of descriptors per pass (entries 0..seq_len-1)
seq_loops_i  in  8  passes over the list; 0 = repeat until abort
seq_gap_i  in  16  idle cycles between consecutive runs
pls_start_o  out  1  start to generator
pls_stop_o  out  1  stop to generator
pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o  out  8 each  generator counts
pls_f1_end_o, pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o  out  16 each  generator timing
pls_state_i  in  3  generator state (0 IDLE, 1 RUN_F1, 2 RUN_F2, 3 RUN_STOP, 4 DONE)
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse: sequence completed normally
aborted_o  out  1  one-cycle pulse: sequence aborted
cur_idx_o  out  IW  descriptor currently loaded
cur_pass_o  out  8  completed-pass count, wraps at 255

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; descriptor table contents are not reset (undefined until written).
- Table writes: accepted in every state and take effect next cycle. Configuration outputs are registers loaded only in S_LOAD, so a write during a run affects only later loads.
- On seq_start_i, seq_len_i, seq_loops_i and seq_gap_i are captured. seq_start_i is ignored while busy_o=1.
- FSM states: S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP.
- S_IDLE:
  - On seq_start_i with seq_len_i=0: stay in S_IDLE and pulse done_o the next cycle.
  - Otherwise: idx=0, pass=0, go to S_LOAD. busy_o=1 from the next cycle.
- S_LOAD: register table[idx] onto the pls_* config outputs and cur_idx_o=idx, then go to S_START.
- S_START: pls_start_o=1 for exactly one cycle, then go to S_WAIT.
- S_WAIT: wait for pls_state_i==4. This may occur on the first S_WAIT cycle, when the descriptor has all counts zero.
  - When seen: if idx<len-1, idx++.
  - Otherwise (end of pass): idx=0 and pass++ (and cur_pass_o++). If loops!=0 and pass+1==loops, finish: go to S_IDLE, busy_o=0 and done_o=1 in the same cycle.
  - If not finished: go to S_GAP when gap!=0, otherwise directly to S_LOAD.
- S_GAP: 16-bit down-counter loaded with gap-1. Go to S_LOAD when it reaches 0, giving exactly gap idle cycles.
- Timing: seq_start at cycle t gives pls_start_o at t+2. Generator DONE seen at cycle d gives the next pls_start_o at d+2 (gap=0) or d+2+gap.
- Config outputs hold their values from S_LOAD until the next S_LOAD. After finish or abort they stay at their last values.
- seq_abort_i in any non-idle state has priority over every other transition:
  - pls_stop_o=1 for one cycle;
  - aborted_o=1 in the same cycle;
  - go to S_IDLE with busy_o=0 next cycle;
  - done_o is not asserted.
  - In S_IDLE, seq_abort_i is ignored.
- Simultaneous seq_start_i and seq_abort_i in S_IDLE: start wins.
- pls_start_o and pls_stop_o are never asserted in the same cycle.
- Asynchronous reset mid-run returns the FSM to S_IDLE and clears all outputs immediately. The generator is reset by the same rst_ni.

Test Plan:
- Single run: entry0={f1_cnt=2,f1_end=4,f1_switch=2, all other fields 0}, len=1, loops=1, gap=0, start at t -> pls_start_o at t+2 only, done_o one cycle after pls_state_i==4, busy_o low afterwards, exactly one start pulse.
- Three descriptors, loops=2, gap=5 -> six pls_start_o pulses with cur_idx_o 0,1,2,0,1,2; between each DONE and the next start exactly 7 cycles; cur_pass_o ends at 2.
- Empty and all-zero cases: len=0 -> done_o next cycle with no pls_start_o; entry with all counts 0 -> generator goes straight to DONE and the sequencer advances without hanging.
- Abort during S_WAIT and during S_GAP -> pls_stop_o and aborted_o together for one cycle, no done_o, busy_o=0 next cycle, a new start afterwards runs normally from idx 0.
- Infinite loops=0, len=2 -> keeps alternating idx 0/1 for 10+ passes with cur_pass_o incrementing; only an abort terminates it.
- Table write to the currently running entry mid-run -> current pls_* outputs unchanged; the new values appear at that entry's next S_LOAD. Reset asserted mid-run -> all outputs 0 immediately.
